// File: rtl/chasy_setup_ctrl.sv
// Time-setup controller: captures RTC time into a shadow register, edits hour/min/sec, strobes the result back.
// Optional blink generator enabled by defining CHASY_SETUP_BLINK_EN.
module chasy_setup_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 500000000,
    parameter int unsigned BLINK_HALF  = 25000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        btn_mode,
    input  logic        btn_inc,
    input  logic        btn_dec,
    input  logic [23:0] cur_time,
    output logic [23:0] setup_data,
    output logic        setup_imp,
    output logic        edit_active,
    output logic [1:0]  edit_field,
    output logic        blink
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EDIT_HOUR,
        S_EDIT_MIN,
        S_EDIT_SEC,
        S_COMMIT
    } state_t;

    localparam int unsigned TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    state_t          state;
    state_t          state_next;
    logic [23:0]     shadow;
    logic [23:0]     shadow_next;
    logic [TO_W-1:0] to_cnt;
    logic            to_phase;
    logic            to_clear;
    logic            in_edit;
    logic            any_btn;
    logic            adjust;
    logic [7:0]      fld_cur;
    logic [7:0]      fld_max;
    logic [7:0]      fld_new;

    function automatic logic is_edit(input state_t s);
        return (s == S_EDIT_HOUR) || (s == S_EDIT_MIN) || (s == S_EDIT_SEC);
    endfunction

    function automatic logic [1:0] field_of(input state_t s);
        case (s)
            S_EDIT_HOUR: return 2'd1;
            S_EDIT_MIN:  return 2'd2;
            S_EDIT_SEC:  return 2'd3;
            default:     return 2'd0;
        endcase
    endfunction

    assign in_edit = is_edit(state);
    assign any_btn = btn_mode | btn_inc | btn_dec;
    assign adjust  = ~btn_mode & (btn_inc ^ btn_dec);

    // Selected field and its wrapped +1/-1 value; out-of-range captures saturate to 0 or max
    always_comb begin
        fld_cur = 8'd0;
        fld_max = 8'd59;
        case (state)
            S_EDIT_HOUR: begin
                fld_cur = shadow[23:16];
                fld_max = 8'd23;
            end
            S_EDIT_MIN:  fld_cur = shadow[15:8];
            S_EDIT_SEC:  fld_cur = shadow[7:0];
            default:     fld_cur = 8'd0;
        endcase
        if (btn_inc) begin
            fld_new = (fld_cur >= fld_max) ? 8'd0 : fld_cur + 8'd1;
        end else begin
            fld_new = ((fld_cur == 8'd0) || (fld_cur > fld_max)) ? fld_max : fld_cur - 8'd1;
        end
    end

    always_comb begin
        state_next  = state;
        shadow_next = shadow;
        to_clear    = in_edit & any_btn;
        case (state)
            S_IDLE: begin
                if (btn_mode) begin
                    state_next  = S_EDIT_HOUR;
                    shadow_next = cur_time;
                    to_clear    = 1'b1;
                end
            end
            S_EDIT_HOUR: begin
                if (btn_mode) begin
                    state_next = S_EDIT_MIN;
                end else if (adjust) begin
                    shadow_next[23:16] = fld_new;
                end
            end
            S_EDIT_MIN: begin
                if (btn_mode) begin
                    state_next = S_EDIT_SEC;
                end else if (adjust) begin
                    shadow_next[15:8] = fld_new;
                end
            end
            S_EDIT_SEC: begin
                if (btn_mode) begin
                    state_next = S_COMMIT;
                end else if (adjust) begin
                    shadow_next[7:0] = fld_new;
                end
            end
            S_COMMIT: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
        // Abort without loading the RTC; any button press restarts the wait instead
        if (in_edit && !any_btn && (to_cnt == TO_LAST)) begin
            state_next = S_IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= S_IDLE;
            shadow      <= 24'd0;
            setup_imp   <= 1'b0;
            edit_active <= 1'b0;
            edit_field  <= 2'd0;
        end else begin
            state       <= state_next;
            shadow      <= shadow_next;
            setup_imp   <= (state_next == S_COMMIT);
            edit_active <= is_edit(state_next);
            edit_field  <= field_of(state_next);
        end
    end

    // Phase bit halves the count rate, so the counter advances every other edit cycle
    always_ff @(posedge clock) begin
        if (!reset) begin
            to_cnt   <= '0;
            to_phase <= 1'b0;
        end else if (to_clear || !is_edit(state_next)) begin
            to_cnt   <= '0;
            to_phase <= 1'b0;
        end else begin
            to_phase <= ~to_phase;
            if (to_phase) begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    assign setup_data = shadow;

`ifdef CHASY_SETUP_BLINK_EN
    localparam int unsigned BL_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_HALF - 1);

    logic [BL_W-1:0] blink_cnt;
    logic            blink_q;

    // Each newly selected field starts visible so the user sees it at once
    always_ff @(posedge clock) begin
        if (!reset) begin
            blink_cnt <= '0;
            blink_q   <= 1'b0;
        end else if (!is_edit(state_next)) begin
            blink_cnt <= '0;
            blink_q   <= 1'b0;
        end else if (field_of(state_next) != edit_field) begin
            blink_cnt <= '0;
            blink_q   <= 1'b1;
        end else if (blink_cnt == BL_LAST) begin
            blink_cnt <= '0;
            blink_q   <= ~blink_q;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign blink = blink_q;
`else
    assign blink = 1'b0;
`endif

endmodule

// File: tb/tb_chasy_setup_ctrl.sv
// Directed self-checking bench for chasy_setup_ctrl with TIMEOUT_CYC=20 and BLINK_HALF=4.
module tb_chasy_setup_ctrl;

`ifdef CHASY_SETUP_BLINK_EN
    localparam bit BLINK_BUILD = 1'b1;
`else
    localparam bit BLINK_BUILD = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        btn_mode = 1'b0;
    logic        btn_inc = 1'b0;
    logic        btn_dec = 1'b0;
    logic [23:0] cur_time = 24'd0;
    logic [23:0] setup_data;
    logic        setup_imp;
    logic        edit_active;
    logic [1:0]  edit_field;
    logic        blink;

    int assertCount = 0;
    int failCount   = 0;
    int strobeCount = 0;

    chasy_setup_ctrl #(
        .TIMEOUT_CYC(20),
        .BLINK_HALF (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .btn_dec    (btn_dec),
        .cur_time   (cur_time),
        .setup_data (setup_data),
        .setup_imp  (setup_imp),
        .edit_active(edit_active),
        .edit_field (edit_field),
        .blink      (blink)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (setup_imp === 1'b1) strobeCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic m, input logic i, input logic d);
        btn_mode = m;
        btn_inc  = i;
        btn_dec  = d;
        tick();
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        btn_dec  = 1'b0;
    endtask

    initial begin
        int n;

        tick();
        tick();
        checkOutput("rst_data", 32'(setup_data), 32'h0);
        checkOutput("rst_imp", 32'(setup_imp), 32'h0);
        checkOutput("rst_active", 32'(edit_active), 32'h0);
        checkOutput("rst_field", 32'(edit_field), 32'h0);
        checkOutput("rst_blink", 32'(blink), 32'h0);
        reset = 1'b1;
        tick();

        // Commit 12:34:56 -> 13:34:56
        cur_time = 24'h0C2238;
        applyStimulus(1, 0, 0);
        checkOutput("c_active", 32'(edit_active), 32'h1);
        checkOutput("c_field_h", 32'(edit_field), 32'h1);
        checkOutput("c_capture", 32'(setup_data), 32'h0C2238);
        cur_time = 24'h0C2239;
        applyStimulus(0, 1, 0);
        checkOutput("c_hour_inc", 32'(setup_data), 32'h0D2238);
        applyStimulus(1, 0, 0);
        checkOutput("c_field_m", 32'(edit_field), 32'h2);
        applyStimulus(1, 0, 0);
        checkOutput("c_field_s", 32'(edit_field), 32'h3);
        checkOutput("c_no_strobe_yet", 32'(strobeCount), 32'h0);
        applyStimulus(1, 0, 0);
        checkOutput("c_imp", 32'(setup_imp), 32'h1);
        checkOutput("c_data", 32'(setup_data), 32'h0D2238);
        checkOutput("c_commit_active", 32'(edit_active), 32'h0);
        tick();
        checkOutput("c_imp_drop", 32'(setup_imp), 32'h0);
        checkOutput("c_one_strobe", 32'(strobeCount), 32'h1);

        // Wrap: 23:59:00 -> 00:00:59
        cur_time = 24'h173B00;
        applyStimulus(1, 0, 0);
        applyStimulus(0, 1, 0);
        checkOutput("w_hour", 32'(setup_data), 32'h003B00);
        applyStimulus(1, 0, 0);
        applyStimulus(0, 1, 0);
        checkOutput("w_min", 32'(setup_data), 32'h000000);
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 1);
        checkOutput("w_sec", 32'(setup_data), 32'h00003B);
        applyStimulus(1, 0, 0);
        checkOutput("w_imp", 32'(setup_imp), 32'h1);
        checkOutput("w_data", 32'(setup_data), 32'h00003B);
        tick();

        // Captured fields above max: 30:70:99
        cur_time = {8'd30, 8'd70, 8'd99};
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 1);
        checkOutput("o_hour_dec", 32'(setup_data), 32'h174663);
        applyStimulus(0, 1, 0);
        checkOutput("o_hour_inc", 32'(setup_data), 32'h004663);
        applyStimulus(1, 0, 0);
        applyStimulus(0, 1, 0);
        checkOutput("o_min_inc", 32'(setup_data), 32'h000063);
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 1);
        checkOutput("o_sec_dec", 32'(setup_data), 32'h00003B);
        applyStimulus(1, 0, 0);
        tick();
        checkOutput("o_strobes", 32'(strobeCount), 32'h3);

        // Idle buttons are ignored, then conflicting presses
        cur_time = 24'h0A0B0C;
        applyStimulus(0, 1, 0);
        applyStimulus(0, 0, 1);
        checkOutput("i_active", 32'(edit_active), 32'h0);
        checkOutput("i_data", 32'(setup_data), 32'h00003B);
        applyStimulus(1, 0, 0);
        applyStimulus(0, 1, 1);
        checkOutput("x_incdec_data", 32'(setup_data), 32'h0A0B0C);
        checkOutput("x_incdec_field", 32'(edit_field), 32'h1);
        applyStimulus(1, 1, 0);
        checkOutput("x_modeinc_field", 32'(edit_field), 32'h2);
        checkOutput("x_modeinc_data", 32'(setup_data), 32'h0A0B0C);

        // Timeout from EDIT_MIN with no buttons
        n = 0;
        while (edit_active === 1'b1 && n < 60) begin
            tick();
            n++;
        end
        checkOutput("t_exit", 32'(edit_active), 32'h0);
        checkOutput("t_not_early", 32'(n >= 20), 32'h1);
        checkOutput("t_field", 32'(edit_field), 32'h0);
        checkOutput("t_no_strobe", 32'(strobeCount), 32'h3);
        checkOutput("t_shadow_kept", 32'(setup_data), 32'h0A0B0C);

        // Reset in EDIT_SEC
        applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 0);
        checkOutput("r_in_sec", 32'(edit_field), 32'h3);
        reset = 1'b0;
        tick();
        checkOutput("r_data", 32'(setup_data), 32'h0);
        checkOutput("r_active", 32'(edit_active), 32'h0);
        checkOutput("r_field", 32'(edit_field), 32'h0);
        checkOutput("r_imp", 32'(setup_imp), 32'h0);
        checkOutput("r_blink", 32'(blink), 32'h0);
        reset = 1'b1;
        tick();

        // Reset coinciding with the commit press
        applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 0);
        reset = 1'b0;
        applyStimulus(1, 0, 0);
        checkOutput("rc_imp", 32'(setup_imp), 32'h0);
        reset = 1'b1;
        tick();
        checkOutput("rc_strobes", 32'(strobeCount), 32'h3);

        // Blink: 4 cycles on, 4 off, restart on field change, off after commit
        applyStimulus(1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("b_phase%0d", i), 32'(blink), 32'(BLINK_BUILD && (i < 4)));
            tick();
        end
        applyStimulus(1, 0, 0);
        checkOutput("b_restart", 32'(blink), 32'(BLINK_BUILD));
        tick();
        tick();
        tick();
        checkOutput("b_still_on", 32'(blink), 32'(BLINK_BUILD));
        applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 0);
        checkOutput("b_commit", 32'(blink), 32'h0);
        checkOutput("b_commit_imp", 32'(setup_imp), 32'h1);
        tick();
        checkOutput("b_idle", 32'(blink), 32'h0);
        checkOutput("b_strobes", 32'(strobeCount), 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
